output_port_cluster_rr: RTL and testbench
=========================================

Name: output_port_cluster_rr

Overview:
- Parametrised successor to the single-port output cluster: NUM_OUT_PORTS user output channels share one NoC injection interface.
- Each channel has a local FIFO, a per-destination packet header (dst_leaf/dst_port/fifo_addr), a write-address generator and a freespace credit counter.
- A round-robin arbiter picks one eligible channel per packet and drives a registered valid/ready packet output toward the leaf interface.
- Per-channel full/stall performance counters replace the hard-wired port-0-only counters.

Parameters:
NUM_OUT_PORTS, 4, number of user output channels (1..16)
PAYLOAD_BITS, 64, user word / packet payload width
NUM_LEAF_BITS, 6, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, remote FIFO address and freespace width
FIFO_DEPTH_BITS, 2, log2 local FIFO depth per channel (depth 4 default)
CNT_BITS, 32, performance counter width
PACKET_BITS (localparam), 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS, packet {vld,leaf,port,addr,payload}, MSB first

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-low
din_user  in  PAYLOAD_BITS*NUM_OUT_PORTS  user data, channel i at [PAYLOAD_BITS*(i+1)-1 : PAYLOAD_BITS*i]
vld_user  in  NUM_OUT_PORTS  user word valid
ack_user  out  NUM_OUT_PORTS  FIFO not full; word accepted when vld_user&ack_user
cfg_wr  in  1  load header/base address/freespace for channel cfg_sel
cfg_sel  in  clog2(NUM_OUT_PORTS)  channel index
cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_dst_port  in  NUM_PORT_BITS  destination port
cfg_fifo_addr  in  NUM_ADDR_BITS  base write address
cfg_freespace  in  NUM_ADDR_BITS  initial credits
credit_vld  in  1  credit return strobe
credit_sel  in  clog2(NUM_OUT_PORTS)  channel receiving credits
credit_amt  in  NUM_ADDR_BITS  credits returned
pkt_out  out  PACKET_BITS  packet to NoC
pkt_vld  out  1  pkt_out valid
pkt_rdy  in  1  NoC accepts when pkt_vld&pkt_rdy
is_done_mode  in  1  freezes performance counters
full_cnt  out  CNT_BITS*NUM_OUT_PORTS  cycles with vld_user & ~ack_user
stall_cnt  out  CNT_BITS*NUM_OUT_PORTS  cycles with FIFO non-empty & credits==0
stall_any  out  1  OR over channels of (FIFO non-empty & credits==0)

Behaviour:
- Reset (reset==0 at posedge): FIFOs empty, credits=0, headers/addresses=0, rr pointer=0, pkt_vld=0, pkt_out=0, counters=0. ack_user is combinational, so it reads all-1 once the FIFOs are empty. Reset mid-transfer drops all buffered words and any in-flight pkt_out.
- FIFO: write on vld_user&ack_user. Full means ack_user=0. Simultaneous read/write on a full FIFO still does not accept the write; ack depends only on the registered full flag.
- Eligible[i] = FIFO non-empty & credits[i]!=0.
- Output register: loads when pkt_vld==0 or pkt_rdy==1 (skid-free, one register). On load with any eligible channel:
  - grant = first eligible at or after rr_ptr (wrapping);
  - pop that FIFO;
  - pkt_out = {1'b1, leaf, port, addr[g], data};
  - addr[g] += 1 mod 2^NUM_ADDR_BITS;
  - credits[g] -= 1;
  - rr_ptr = g+1 mod NUM_OUT_PORTS;
  - pkt_vld = 1.
- On load with no eligible channel: pkt_vld=0, pkt_out[MSB]=0.
- Latency: a user word written at cycle t appears on pkt_out at t+2 at the earliest (FIFO registered, output registered).
- pkt_vld/pkt_out hold stable while pkt_vld & ~pkt_rdy.
- Credits are saturating NUM_ADDR_BITS. The same-cycle decrement and credit return on one channel net to credits - 1 + amt, saturating at 2^NUM_ADDR_BITS-1. cfg_wr to a channel overrides both in that cycle.
- cfg_wr overwrites header, addr and credits of cfg_sel. It is legal only while that channel's FIFO is empty. Otherwise it is still applied, and queued words use the new header.
- Counters increment when their condition holds and is_done_mode==0. They saturate at all-ones.
- Out-of-range cfg_sel or credit_sel (>= NUM_OUT_PORTS) is ignored.

Decomposition:
- Shared package: PACKET_BITS field offsets (VLD_POS, LEAF_LSB, PORT_LSB, ADDR_LSB), the clog2 function, and the packet-assembly function.
- One sub-module: oport_chan_fifo (parametrised sync FIFO with full/empty), instantiated NUM_OUT_PORTS times.
- Arbiter, credit and counter logic stay inline.

Test Plan:
- Reset then cfg ch0 leaf=5,port=2,addr=0x7E,free=3; push 4 words -> 3 packets with addr 0x7E,0x7F,0x00 (wrap); 4th held; stall_any=1; stall_cnt[0] increments.
- Then credit_vld ch0 amt=1 -> 4th packet emitted 2 cycles later; stall_any=0.
- All 4 channels free=8, each pushes 2 words at once -> grant order ch0,1,2,3,0,1,2,3.
- pkt_rdy=0 for 5 cycles with pkt_vld=1 -> pkt_out stable; no FIFO pops; credits unchanged.
- Fill ch1 FIFO (4 words, credits=0), hold vld_user for 10 cycles -> ack_user[1]=0 and full_cnt[1]=10. Repeat with is_done_mode=1 -> count frozen.
- Credit return amt=1 on ch2 in the same cycle as its packet send, credits=1 -> credits stay 1. Then assert reset=0 mid-stream -> pkt_vld=0 next cycle and all counters 0.

Source files
------------

// File: rtl/output_port_cluster_rr_pkg.sv
// output_port_cluster_rr_pkg: packet field layout, clog2 and packet assembly helpers
package output_port_cluster_rr_pkg;
  localparam int MAX_PKT_BITS = 512;
  typedef logic [MAX_PKT_BITS-1:0] wide_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction
  function automatic int sel_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
  function automatic int addr_lsb(input int pb);
    return pb;
  endfunction
  function automatic int port_lsb(input int pb, input int ab);
    return pb + ab;
  endfunction
  function automatic int leaf_lsb(input int pb, input int ab, input int qb);
    return pb + ab + qb;
  endfunction
  function automatic int vld_pos(input int pb, input int ab, input int qb, input int lb);
    return pb + ab + qb + lb;
  endfunction
  function automatic wide_t pack_pkt(input int pb, input int ab, input int qb, input int lb,
                                     input wide_t leaf, input wide_t port, input wide_t addr,
                                     input wide_t payload);
    return (wide_t'(1) << vld_pos(pb, ab, qb, lb)) | (leaf << leaf_lsb(pb, ab, qb)) |
           (port << port_lsb(pb, ab)) | (addr << addr_lsb(pb)) | payload;
  endfunction
endpackage

// File: rtl/output_port_cluster_rr_fifo.sv
// oport_chan_fifo: synchronous FIFO with registered full/empty flags
module oport_chan_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0] cnt_q, cnt_d;
  logic full_q, full_d, empty_q, empty_d, do_wr, do_rd;
  always_comb begin
    do_wr = wr_en & ~full_q;
    do_rd = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + DEPTH_BITS'(do_wr);
    rd_ptr_d = rd_ptr_q + DEPTH_BITS'(do_rd);
    cnt_d = cnt_q + (DEPTH_BITS+1)'(do_wr) - (DEPTH_BITS+1)'(do_rd);
    full_d = cnt_d == (DEPTH_BITS+1)'(DEPTH);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign full = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/output_port_cluster_rr.sv
// output_port_cluster_rr: round-robin arbitration of buffered user channels onto one credited NoC packet port
module output_port_cluster_rr
  import output_port_cluster_rr_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS = 64,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS = 32,
  localparam int SEL_BITS = sel_bits(NUM_OUT_PORTS),
  localparam int PACKET_BITS = vld_pos(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS, NUM_LEAF_BITS) + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]          vld_user,
  output logic [NUM_OUT_PORTS-1:0]          ack_user,
  input  logic                              cfg_wr,
  input  logic [SEL_BITS-1:0]               cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
  input  logic [NUM_ADDR_BITS-1:0]          cfg_fifo_addr,
  input  logic [NUM_ADDR_BITS-1:0]          cfg_freespace,
  input  logic                              credit_vld,
  input  logic [SEL_BITS-1:0]               credit_sel,
  input  logic [NUM_ADDR_BITS-1:0]          credit_amt,
  output logic [PACKET_BITS-1:0]            pkt_out,
  output logic                              pkt_vld,
  input  logic                              pkt_rdy,
  input  logic                              is_done_mode,
  output logic [CNT_BITS*NUM_OUT_PORTS-1:0] full_cnt,
  output logic [CNT_BITS*NUM_OUT_PORTS-1:0] stall_cnt,
  output logic                              stall_any
);
  logic [NUM_OUT_PORTS-1:0] full, empty, wr_en, rd_en, elig, full_hit, stall_hit;
  logic [PAYLOAD_BITS-1:0] dout [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_q [NUM_OUT_PORTS], leaf_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_q [NUM_OUT_PORTS], port_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q [NUM_OUT_PORTS], addr_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] cred_q [NUM_OUT_PORTS], cred_d [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0] full_cnt_q [NUM_OUT_PORTS], full_cnt_d [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0] stall_cnt_q [NUM_OUT_PORTS], stall_cnt_d [NUM_OUT_PORTS];
  logic [SEL_BITS-1:0] rr_q, rr_d, gnt, idx;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic pkt_vld_q, pkt_vld_d, load, pop, cfg_hit, cr_hit;
  logic [NUM_ADDR_BITS:0] cred_sum;
  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_chan
    oport_chan_fifo #(
      .WIDTH(PAYLOAD_BITS),
      .DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en[i]),
      .wr_data(din_user[PAYLOAD_BITS*i +: PAYLOAD_BITS]),
      .rd_en(rd_en[i]),
      .rd_data(dout[i]),
      .full(full[i]),
      .empty(empty[i])
    );
    assign full_cnt[CNT_BITS*i +: CNT_BITS] = full_cnt_q[i];
    assign stall_cnt[CNT_BITS*i +: CNT_BITS] = stall_cnt_q[i];
  end
  assign ack_user = ~full;
  assign wr_en = vld_user & ~full;
  assign full_hit = vld_user & full;
  assign stall_any = |stall_hit;
  assign pkt_out = pkt_q;
  assign pkt_vld = pkt_vld_q;
  always_comb begin
    load = ~pkt_vld_q | pkt_rdy;
    gnt = '0;
    idx = '0;
    cfg_hit = 1'b0;
    cr_hit = 1'b0;
    cred_sum = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      elig[k] = ~empty[k] & (cred_q[k] != '0);
      stall_hit[k] = ~empty[k] & (cred_q[k] == '0);
    end
    for (int k = NUM_OUT_PORTS - 1; k >= 0; k--) begin
      idx = SEL_BITS'((int'(rr_q) + k) % NUM_OUT_PORTS);
      gnt = elig[idx] ? idx : gnt;
    end
    pop = load & (|elig);
    rd_en = '0;
    rd_en[gnt] = pop;
    pkt_vld_d = load ? (|elig) : pkt_vld_q;
    pkt_d = !load ? pkt_q : !pop ? '0 :
            PACKET_BITS'(pack_pkt(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS, NUM_LEAF_BITS,
                                  wide_t'(leaf_q[gnt]), wide_t'(port_q[gnt]),
                                  wide_t'(addr_q[gnt]), wide_t'(dout[gnt])));
    rr_d = !pop ? rr_q : (int'(gnt) == NUM_OUT_PORTS - 1) ? '0 : gnt + SEL_BITS'(1);
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cfg_hit = cfg_wr && (cfg_sel == SEL_BITS'(k));
      cr_hit = credit_vld && (credit_sel == SEL_BITS'(k));
      cred_sum = {1'b0, cred_q[k]} + (cr_hit ? {1'b0, credit_amt} : '0) - (NUM_ADDR_BITS+1)'(rd_en[k]);
      leaf_d[k] = cfg_hit ? cfg_dst_leaf : leaf_q[k];
      port_d[k] = cfg_hit ? cfg_dst_port : port_q[k];
      addr_d[k] = cfg_hit ? cfg_fifo_addr : addr_q[k] + NUM_ADDR_BITS'(rd_en[k]);
      cred_d[k] = cfg_hit ? cfg_freespace : cred_sum[NUM_ADDR_BITS] ? '1 : cred_sum[NUM_ADDR_BITS-1:0];
      full_cnt_d[k] = full_cnt_q[k] + CNT_BITS'(full_hit[k] & ~is_done_mode & ~(&full_cnt_q[k]));
      stall_cnt_d[k] = stall_cnt_q[k] + CNT_BITS'(stall_hit[k] & ~is_done_mode & ~(&stall_cnt_q[k]));
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      leaf_q <= '{default: '0};
      port_q <= '{default: '0};
      addr_q <= '{default: '0};
      cred_q <= '{default: '0};
      full_cnt_q <= '{default: '0};
      stall_cnt_q <= '{default: '0};
      rr_q <= '0;
      pkt_q <= '0;
      pkt_vld_q <= 1'b0;
    end else begin
      leaf_q <= leaf_d;
      port_q <= port_d;
      addr_q <= addr_d;
      cred_q <= cred_d;
      full_cnt_q <= full_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rr_q <= rr_d;
      pkt_q <= pkt_d;
      pkt_vld_q <= pkt_vld_d;
    end
  end
endmodule

// File: tb/tb_output_port_cluster_rr.sv
// tb_output_port_cluster_rr: directed scoreboard bench for the round-robin output cluster
module tb_output_port_cluster_rr;
  localparam int N = 4, PB = 64, CB = 32, PKB = 82;
  typedef logic [127:0] v_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [PB*N-1:0] din_user = '0;
  logic [N-1:0] vld_user = '0;
  logic [N-1:0] ack_user;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [5:0] cfg_dst_leaf = '0;
  logic [3:0] cfg_dst_port = '0;
  logic [6:0] cfg_fifo_addr = '0;
  logic [6:0] cfg_freespace = '0;
  logic credit_vld = 1'b0;
  logic [1:0] credit_sel = '0;
  logic [6:0] credit_amt = '0;
  logic [PKB-1:0] pkt_out;
  logic pkt_vld;
  logic pkt_rdy = 1'b1;
  logic is_done_mode = 1'b0;
  logic [CB*N-1:0] full_cnt, stall_cnt;
  logic stall_any;
  int n_cmp = 0;
  int n_err = 0;
  logic [PKB-1:0] exp_q [$];
  always #5 clk = ~clk;
  output_port_cluster_rr dut (
    .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_dst_leaf(cfg_dst_leaf), .cfg_dst_port(cfg_dst_port),
    .cfg_fifo_addr(cfg_fifo_addr), .cfg_freespace(cfg_freespace), .credit_vld(credit_vld),
    .credit_sel(credit_sel), .credit_amt(credit_amt), .pkt_out(pkt_out), .pkt_vld(pkt_vld),
    .pkt_rdy(pkt_rdy), .is_done_mode(is_done_mode), .full_cnt(full_cnt), .stall_cnt(stall_cnt),
    .stall_any(stall_any)
  );
  function automatic logic [PKB-1:0] mk(input logic [5:0] leaf, input logic [3:0] port,
                                        input logic [6:0] addr, input logic [63:0] data);
    return {1'b1, leaf, port, addr, data};
  endfunction
  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int ch, input logic [63:0] d);
    din_user[PB*ch +: PB] = d;
    vld_user[ch] = 1'b1;
  endtask
  task automatic cfg(input logic [1:0] ch, input logic [5:0] leaf, input logic [3:0] port,
                     input logic [6:0] addr, input logic [6:0] free);
    cfg_wr = 1'b1;
    cfg_sel = ch;
    cfg_dst_leaf = leaf;
    cfg_dst_port = port;
    cfg_fifo_addr = addr;
    cfg_freespace = free;
    tick();
    cfg_wr = 1'b0;
  endtask
  task automatic drain(input string tag);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      tick();
      b++;
    end
    chk(tag, v_t'(exp_q.size()), v_t'(0));
  endtask
  always @(negedge clk) begin
    if (reset && pkt_vld && pkt_rdy) begin
      if (exp_q.size() == 0) chk("pkt_extra", v_t'(pkt_out), v_t'(0));
      else chk("pkt", v_t'(pkt_out), v_t'(exp_q.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] d;
    tick();
    tick();
    chk("rst_vld", v_t'(pkt_vld), v_t'(0));
    chk("rst_pkt", v_t'(pkt_out), v_t'(0));
    chk("rst_ack", v_t'(ack_user), v_t'(4'hF));
    chk("rst_stall_any", v_t'(stall_any), v_t'(0));
    chk("rst_full_cnt", v_t'(full_cnt), v_t'(0));
    chk("rst_stall_cnt", v_t'(stall_cnt), v_t'(0));
    reset = 1'b1;
    cfg(2'd0, 6'd5, 4'd2, 7'h7E, 7'd3);
    for (int k = 0; k < 4; k++) begin
      d = 64'h1111_0000_0000_0000 + 64'(k);
      if (k < 3) exp_q.push_back(mk(6'd5, 4'd2, 7'(126 + k), d));
      chk("t1_ack", v_t'(ack_user[0]), v_t'(1));
      put(0, d);
      tick();
    end
    vld_user = '0;
    chk("t1_stall_any", v_t'(stall_any), v_t'(1));
    chk("t1_stall_cnt0_a", v_t'(stall_cnt[0 +: CB]), v_t'(0));
    tick();
    tick();
    tick();
    chk("t1_stall_cnt0_b", v_t'(stall_cnt[0 +: CB]), v_t'(3));
    chk("t1_held", v_t'(pkt_vld), v_t'(0));
    chk("t1_q_empty", v_t'(exp_q.size()), v_t'(0));
    exp_q.push_back(mk(6'd5, 4'd2, 7'h01, 64'h1111_0000_0000_0003));
    credit_vld = 1'b1;
    credit_sel = 2'd0;
    credit_amt = 7'd1;
    tick();
    credit_vld = 1'b0;
    chk("t1_cr_vld0", v_t'(pkt_vld), v_t'(0));
    chk("t1_cr_stall", v_t'(stall_any), v_t'(0));
    tick();
    chk("t1_cr_vld1", v_t'(pkt_vld), v_t'(1));
    chk("t1_cr_pkt", v_t'(pkt_out), v_t'(mk(6'd5, 4'd2, 7'h01, 64'h1111_0000_0000_0003)));
    drain("t1_drain");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) cfg(2'(c), 6'(10 + c), 4'(c + 1), 7'(16 * c + 3), 7'd8);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 4; c++) begin
        d = 64'hA000_0000_0000_0000 + 64'(16 * c + w);
        exp_q.push_back(mk(6'(10 + c), 4'(c + 1), 7'(16 * c + 3 + w), d));
        put(c, d);
      end
      tick();
    end
    vld_user = '0;
    drain("t2_drain");
    pkt_rdy = 1'b0;
    put(0, 64'hB0);
    tick();
    put(0, 64'hB1);
    tick();
    vld_user = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_vld", v_t'(pkt_vld), v_t'(1));
      chk("t3_hold_pkt", v_t'(pkt_out), v_t'(mk(6'd10, 4'd1, 7'd5, 64'hB0)));
      tick();
    end
    exp_q.push_back(mk(6'd10, 4'd1, 7'd5, 64'hB0));
    exp_q.push_back(mk(6'd10, 4'd1, 7'd6, 64'hB1));
    pkt_rdy = 1'b1;
    drain("t3_drain");
    cfg(2'd1, 6'd11, 4'd2, 7'h13, 7'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_ack_fill", v_t'(ack_user[1]), v_t'(1));
      put(1, 64'hC0 + 64'(k));
      tick();
    end
    chk("t4_ack_full", v_t'(ack_user[1]), v_t'(0));
    chk("t4_full_cnt_a", v_t'(full_cnt[CB +: CB]), v_t'(0));
    repeat (10) tick();
    chk("t4_full_cnt_b", v_t'(full_cnt[CB +: CB]), v_t'(10));
    chk("t4_stall_any", v_t'(stall_any), v_t'(1));
    is_done_mode = 1'b1;
    repeat (10) tick();
    chk("t4_frozen", v_t'(full_cnt[CB +: CB]), v_t'(10));
    chk("t4_ack_still", v_t'(ack_user[1]), v_t'(0));
    is_done_mode = 1'b0;
    vld_user = '0;
    cfg(2'd2, 6'd12, 4'd3, 7'h23, 7'd1);
    exp_q.push_back(mk(6'd12, 4'd3, 7'h23, 64'hD0));
    put(2, 64'hD0);
    tick();
    exp_q.push_back(mk(6'd12, 4'd3, 7'h24, 64'hD1));
    put(2, 64'hD1);
    credit_vld = 1'b1;
    credit_sel = 2'd2;
    credit_amt = 7'd1;
    tick();
    credit_vld = 1'b0;
    vld_user = '0;
    drain("t5_drain");
    put(2, 64'hD2);
    tick();
    vld_user = '0;
    repeat (3) tick();
    chk("t5_no_credit", v_t'(pkt_vld), v_t'(0));
    pkt_rdy = 1'b0;
    put(3, 64'hE0);
    tick();
    vld_user = '0;
    tick();
    chk("t6_inflight", v_t'(pkt_vld), v_t'(1));
    reset = 1'b0;
    tick();
    chk("t6_rst_vld", v_t'(pkt_vld), v_t'(0));
    chk("t6_rst_pkt", v_t'(pkt_out), v_t'(0));
    chk("t6_rst_full_cnt", v_t'(full_cnt), v_t'(0));
    chk("t6_rst_stall_cnt", v_t'(stall_cnt), v_t'(0));
    chk("t6_rst_ack", v_t'(ack_user), v_t'(4'hF));
    chk("t6_rst_stall_any", v_t'(stall_any), v_t'(0));
    reset = 1'b1;
    pkt_rdy = 1'b1;
    cfg(2'd1, 6'd11, 4'd2, 7'h13, 7'd4);
    repeat (3) tick();
    chk("t6_dropped", v_t'(pkt_vld), v_t'(0));
    chk("t6_q_empty", v_t'(exp_q.size()), v_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
